mxv_sequencer: RTL
==================

// Module: mxv_sequencer
// PURPOSE
//  Control FSM for the matrix-times-vector (mxv) datapath. On i_start it walks ROWS x COLS
//  element pairs and issues matrix/vector read addresses (row, col). It drives MAC enables
//  delayed by the memory read latency, clears the accumulator per row and writes one result
//  per row. Sits between the top-level command interface and the memories/MAC/accumulator.
// PARAMETERS
//  ROWS    3  matrix rows = number of results written; 1..2**$bits(count_t)
//  COLS    3  matrix columns = vector length = MACs per row; 1..2**$bits(count_t)
//  RD_LAT  1  read latency in cycles from o_rd_en to operand valid at the MAC; 1..4
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  i_start    in   1        start one full mxv; sampled only in IDLE
//  i_abort    in   1        synchronous abort; any state -> IDLE
//  i_stall    in   1        memory not ready; holds address issue in MAC state only
//  o_rd_en    out  1        read strobe for matrix[o_row][o_col] and vector[o_col]
//  o_row      out  count_t  current row; read row in MAC, write address in WRITE
//  o_col      out  count_t  current column / vector index
//  o_mac_en   out  1        operands valid at MAC: o_rd_en delayed RD_LAT cycles
//  o_acc_clr  out  1        clear accumulator, 1-cycle pulse per row
//  o_wr_en    out  1        write accumulator to result[o_row], 1-cycle pulse
//  o_busy     out  1        state != IDLE
//  o_done     out  1        1-cycle pulse after the last row's write
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, row=col=0, delay pipe empty, all outputs 0.
//  - States: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE. All outputs registered or decoded from state.
//  - IDLE: i_start=1 -> CLEAR, row=0. i_start in any other state is ignored.
//  - CLEAR (1 cycle): o_acc_clr=1, col=0 -> MAC.
//  - MAC: if !i_stall: o_rd_en=1 with (row,col). col==COLS-1 -> DRAIN, else col+1.
//    If i_stall: o_rd_en=0, row/col held, state held. Stall is ignored outside MAC.
//  - The delay pipe (RD_LAT-deep shift of o_rd_en) always advances: o_mac_en(t)=o_rd_en(t-RD_LAT).
//  - DRAIN: hold until the pipe holds no 1s beyond the current o_mac_en (last MAC visible)
//    -> WRITE. For RD_LAT=1 with no stalls, DRAIN lasts exactly 1 cycle.
//  - WRITE (1 cycle): o_wr_en=1, o_row=row. row==ROWS-1 -> DONE, else row+1 -> CLEAR.
//  - DONE (1 cycle): o_done=1 -> IDLE. o_busy=0 only in IDLE.
//  - Timing, ROWS=COLS=3, RD_LAT=1, no stall, start sampled at edge 0:
//    each row takes 6 cycles (CLEAR, 3xMAC, DRAIN, WRITE). Row r spans cycles 1+6r..6+6r.
//    o_wr_en at cycles 6, 12, 18. o_done at cycle 19. o_busy=1 in cycles 1..19.
//  - Wrap: counters wrap explicitly at COLS-1/ROWS-1, never by width overflow.
//    ROWS=1 or COLS=1 is legal.
//  - Abort wins over all other inputs: next cycle IDLE, pipe flushed, o_mac_en=0, no o_wr_en,
//    no o_done. Abort in IDLE is a no-op. Abort together with start in IDLE: stay IDLE.
//  - Reset mid-operation: immediate return to reset values; no partial write is issued.
// STRUCTURE
//  - mxv_pkg: count_t (existing); add mxv_seq_state_e (6-state enum), MXV_ROWS/MXV_COLS
//    defaults, MXV_RD_LAT_MAX=4.
//  - Sub-module mxv_lat_pipe: parameterised RD_LAT-deep valid shift register with flush input;
//    outputs o_mac_en and pipe_busy (OR of the stages).
//  - Row/col counters live inline in the FSM; counter_command is not reused because its wrap
//    point is fixed.
// TESTING
//  1. Reset, then start at edge 0 (3x3, RD_LAT=1) -> rd (r,c) sequence row-major
//     (0,0)..(2,2); wr_en cycles 6/12/18 with row 0/1/2; done cycle 19.
//  2. i_stall=1 for 2 cycles at the 2nd MAC of row 1 -> rd_en low 2 cycles, col held at 1,
//     everything after shifts +2 (done cycle 21); mac_en count stays 9.
//  3. RD_LAT=3 -> mac_en trails rd_en by 3 cycles; DRAIN until the last mac_en;
//     wr_en never precedes the row's last mac_en.
//  4. i_abort at cycle 8 -> IDLE at cycle 9; mac_en=0 from cycle 9; no later wr_en/done;
//     a new start then runs cleanly from row 0.
//  5. i_start pulsed while busy (cycle 5) -> ignored, run identical to scenario 1;
//     start in the DONE cycle also ignored.
//  6. rst low at cycle 10, mid-MAC -> all outputs 0 asynchronously; ROWS=1,COLS=1 run:
//     clr, rd, drain, wr, done at cycles 1..5.

Source files
------------

// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared types and defaults for the matrix-times-vector (mxv) control path.
//   count_t          : row/column counter type used on all address ports
//   mxv_seq_state_e  : sequencer FSM states
//   MXV_ROWS/COLS    : default matrix dimensions
//   MXV_RD_LAT_MAX   : deepest supported memory read latency
// -----------------------------------------------------------------------------
package mxv_pkg;

    localparam int unsigned MXV_CNT_W = 4;

    typedef logic [MXV_CNT_W-1:0] count_t;

    localparam int unsigned MXV_ROWS       = 3;
    localparam int unsigned MXV_COLS       = 3;
    localparam int unsigned MXV_RD_LAT_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } mxv_seq_state_e;

endpackage

// File: rtl/mxv_lat_pipe.sv
// -----------------------------------------------------------------------------
// mxv_lat_pipe
// RD_LAT-deep shift register that delays the read strobe to the point where
// the operands are valid at the MAC.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous reset, active-low
//   i_valid     in   read strobe entering the pipe
//   i_flush     in   synchronous clear of every stage (wins over i_valid)
//   o_mac_en    out  i_valid delayed RD_LAT cycles
//   o_pipe_busy out  OR of the stages still behind o_mac_en, i.e. reads issued
//                    whose MAC enable has not yet appeared (always 0 for RD_LAT=1)
// -----------------------------------------------------------------------------
module mxv_lat_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_flush,
    output logic o_mac_en,
    output logic o_pipe_busy
);

    logic [RD_LAT-1:0] stage_q;
    logic [RD_LAT-1:0] stage_d;

    always_comb begin
        stage_d = '0;
        if (!i_flush) begin
            stage_d[0] = i_valid;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_mac_en = stage_q[RD_LAT-1];

    // The output stage is excluded: once only it holds a 1, the last MAC is
    // visible this cycle and the sequencer may move on to the write.
    always_comb begin
        o_pipe_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
            o_pipe_busy = o_pipe_busy | stage_q[i];
        end
    end

endmodule

// File: rtl/mxv_sequencer.sv
// -----------------------------------------------------------------------------
// mxv_sequencer
// Control FSM for the mxv datapath. On i_start walks ROWS x COLS element pairs
// row-major, issuing (row, col) read addresses, clears the accumulator before
// each row, drives the MAC enable RD_LAT cycles after each read and writes one
// result per row.
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   i_start    in   start a full mxv (sampled only in IDLE)
//   i_abort    in   synchronous abort to IDLE, flushes the latency pipe
//   i_stall    in   memory not ready; holds address issue in MAC only
//   o_rd_en    out  read strobe for matrix[o_row][o_col] / vector[o_col]
//   o_row      out  current row (read row in MAC, write address in WRITE)
//   o_col      out  current column / vector index
//   o_mac_en   out  operands valid at the MAC
//   o_acc_clr  out  accumulator clear, one pulse per row
//   o_wr_en    out  write accumulator to result[o_row]
//   o_busy     out  not IDLE
//   o_done     out  one pulse after the last row's write
// -----------------------------------------------------------------------------
module mxv_sequencer
    import mxv_pkg::*;
#(
    parameter int unsigned ROWS   = MXV_ROWS,
    parameter int unsigned COLS   = MXV_COLS,
    parameter int unsigned RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  logic   i_abort,
    input  logic   i_stall,
    output logic   o_rd_en,
    output count_t o_row,
    output count_t o_col,
    output logic   o_mac_en,
    output logic   o_acc_clr,
    output logic   o_wr_en,
    output logic   o_busy,
    output logic   o_done
);

    localparam count_t ROW_LAST = count_t'(ROWS - 1);
    localparam count_t COL_LAST = count_t'(COLS - 1);

    mxv_seq_state_e state_q, state_d;
    count_t         row_q, row_d;
    count_t         col_q, col_d;
    logic           rd_en;
    logic           mac_en;
    logic           pipe_busy;

    assign rd_en = (state_q == ST_MAC) && !i_stall;

    mxv_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk         (clk),
        .rst_n       (rst),
        .i_valid     (rd_en),
        .i_flush     (i_abort),
        .o_mac_en    (mac_en),
        .o_pipe_busy (pipe_busy)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;

        if (i_abort) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_CLEAR;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    col_d   = '0;
                    state_d = ST_MAC;
                end
                ST_MAC: begin
                    if (!i_stall) begin
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign o_rd_en   = rd_en;
    assign o_row     = row_q;
    assign o_col     = col_q;
    assign o_mac_en  = mac_en;
    assign o_acc_clr = (state_q == ST_CLEAR);
    assign o_wr_en   = (state_q == ST_WRITE);
    assign o_done    = (state_q == ST_DONE);
    assign o_busy    = (state_q != ST_IDLE);

endmodule
